// File: rtl/cv32e40s_xsecure_lfsr.sv
// Galois LFSR that supplies the random word and counter-reset pulse
// used by the dummy-instruction inserter.
// A zero state is never kept: it is replaced by LFSR_SEED, and
// lockup_o flags the replacement for one cycle.
module cv32e40s_xsecure_lfsr #(
    parameter logic [31:0] LFSR_TAPS = 32'h8000_0057,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_we_i,
    input  logic [31:0] seed_wdata_i,
    input  logic        cpuctrl_we_i,
    input  logic        shift_i,
    output logic [31:0] lfsr_o,
    output logic        cntrst_o,
    output logic        lockup_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_step;
    logic [31:0] lfsr_candidate;
    logic        cntrst_q;
    logic        lockup_q;

    // Select the next state: a seed write wins and drops any same-cycle shift.
    always_comb begin
        lfsr_step      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        lfsr_candidate = lfsr_q;
        if (seed_we_i) begin
            lfsr_candidate = seed_wdata_i;
        end else if (shift_i) begin
            lfsr_candidate = lfsr_step;
        end
    end

    // Register the state and the two pulses; a zero candidate reloads the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q   <= LFSR_SEED;
            cntrst_q <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            cntrst_q <= seed_we_i | cpuctrl_we_i;
            if (lfsr_candidate == 32'h0) begin
                lfsr_q   <= LFSR_SEED;
                lockup_q <= 1'b1;
            end else begin
                lfsr_q   <= lfsr_candidate;
                lockup_q <= 1'b0;
            end
        end
    end

    assign lfsr_o   = lfsr_q;
    assign cntrst_o = cntrst_q;
    assign lockup_o = lockup_q;

    // A zero state, if one ever appears, lasts for a single cycle only.
    a_no_stuck_zero : assert property (@(posedge clk) disable iff (rst)
        (lfsr_q == 32'h0) |=> (lfsr_q != 32'h0));

    // A counter-reset pulse always follows a seed or cpuctrl write.
    a_cntrst_cause : assert property (@(posedge clk) disable iff (rst)
        cntrst_q |-> $past(seed_we_i || cpuctrl_we_i));

    // Lockup recovery always leaves the register holding the seed.
    a_lockup_seed : assert property (@(posedge clk) disable iff (rst)
        lockup_q |-> (lfsr_q == LFSR_SEED));

endmodule

// File: tb/tb_cv32e40s_xsecure_lfsr.sv
// Directed bench for cv32e40s_xsecure_lfsr with hand-computed expectations.
module tb_cv32e40s_xsecure_lfsr;

    logic        clk;
    logic        rst;
    logic        seed_we_i;
    logic [31:0] seed_wdata_i;
    logic        cpuctrl_we_i;
    logic        shift_i;
    logic [31:0] lfsr_o;
    logic        cntrst_o;
    logic        lockup_o;

    int compared;
    int mismatched;

    cv32e40s_xsecure_lfsr dut (
        .clk          (clk),
        .rst          (rst),
        .seed_we_i    (seed_we_i),
        .seed_wdata_i (seed_wdata_i),
        .cpuctrl_we_i (cpuctrl_we_i),
        .shift_i      (shift_i),
        .lfsr_o       (lfsr_o),
        .cntrst_o     (cntrst_o),
        .lockup_o     (lockup_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs on the falling edge, then settle just past the rising edge.
    task automatic applyStimulus(input logic r, input logic swe, input logic [31:0] wdata,
                                 input logic cwe, input logic sh);
        @(negedge clk);
        rst          = r;
        seed_we_i    = swe;
        seed_wdata_i = wdata;
        cpuctrl_we_i = cwe;
        shift_i      = sh;
        @(posedge clk);
        #1;
    endtask

    // Compare all three outputs against the expected values.
    task automatic checkOutput(input string tag, input logic [31:0] exp_lfsr,
                               input logic exp_cntrst, input logic exp_lockup);
        compared++;
        assert (lfsr_o === exp_lfsr) else begin
            mismatched++;
            $error("[TB] FAIL %s lfsr_o: observed %h expected %h", tag, lfsr_o, exp_lfsr);
        end
        compared++;
        assert (cntrst_o === exp_cntrst) else begin
            mismatched++;
            $error("[TB] FAIL %s cntrst_o: observed %b expected %b", tag, cntrst_o, exp_cntrst);
        end
        compared++;
        assert (lockup_o === exp_lockup) else begin
            mismatched++;
            $error("[TB] FAIL %s lockup_o: observed %b expected %b", tag, lockup_o, exp_lockup);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        compared     = 0;
        mismatched   = 0;
        rst          = 1'b1;
        seed_we_i    = 1'b0;
        seed_wdata_i = 32'h0;
        cpuctrl_we_i = 1'b0;
        shift_i      = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset", 32'h0000_0001, 1'b0, 1'b0);

        $display("[TB] shift pulses");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("shift1", 32'h8000_0057, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("shift2", 32'hC000_007C, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("shift3", 32'h6000_003E, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("hold", 32'h6000_003E, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("shift4", 32'h3000_001F, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("shift5", 32'h9800_0058, 1'b0, 1'b0);

        $display("[TB] seed writes");
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checkOutput("seed", 32'hDEAD_BEEF, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("seed_after", 32'hDEAD_BEEF, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("shift_seeded", 32'hEF56_DF20, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        checkOutput("seed_and_shift", 32'hDEAD_BEEF, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("seed_and_shift_after", 32'hDEAD_BEEF, 1'b0, 1'b0);

        $display("[TB] zero seed");
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("zero_seed", 32'h0000_0001, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("zero_seed_after", 32'h0000_0001, 1'b0, 1'b0);

        $display("[TB] cpuctrl writes");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("cpuctrl1", 32'h0000_0001, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("cpuctrl2", 32'h0000_0001, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("cpuctrl_after1", 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("cpuctrl_after2", 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("cpuctrl_shift", 32'h8000_0057, 1'b1, 1'b0);

        $display("[TB] shift held with reset");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset2", 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("held1", 32'h8000_0057, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("held2", 32'hC000_007C, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1);
        checkOutput("held_reset", 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("held_reset_after", 32'h0000_0001, 1'b0, 1'b0);

        $display("[TB] backdoor zero state");
        applyStimulus(1'b0, 1'b1, 32'hA5A5_5A5A, 1'b0, 1'b0);
        checkOutput("preforce_seed", 32'hA5A5_5A5A, 1'b1, 1'b0);
        @(negedge clk);
        seed_we_i    = 1'b0;
        seed_wdata_i = 32'h0;
        cpuctrl_we_i = 1'b0;
        shift_i      = 1'b0;
        force dut.lfsr_q = 32'h0;
        #1;
        release dut.lfsr_q;
        @(posedge clk);
        #1;
        checkOutput("force_zero", 32'h0000_0001, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("force_zero_after", 32'h0000_0001, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cv32e40s_xsecure_lfsr.md
Name: cv32e40s_xsecure_lfsr

Overview:
Produces the 32-bit pseudo-random word (lfsr0) that the dummy-instruction generator slices for instruction type, operands and insertion interval. Also produces the one-cycle counter-reset pulse (cntrst) that the generator uses to restart its insertion counter. Sits in the xsecure control path between the CSR write logic (seed and cpuctrl writes) and the dummy-instruction inserter in IF. The LFSR advances each time a dummy or hint instruction retires out of ID.

Parameters:
LFSR_TAPS, 32'h8000_0057, Galois feedback mask XORed into the shifted state when the outgoing bit is 1.
LFSR_SEED, 32'h0000_0001, reset value and lockup-recovery value; must be nonzero.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
seed_we_i  input  1  CSR write strobe for the LFSR seed
seed_wdata_i  input  32  seed value to load
cpuctrl_we_i  input  1  CSR write strobe for cpuctrl (rnddummy/rnddummyfreq changed)
shift_i  input  1  a dummy or hint instruction left ID this cycle; advance the LFSR one step
lfsr_o  output  32  current LFSR state (registered)
cntrst_o  output  1  registered one-cycle pulse requesting dummy-counter reset
lockup_o  output  1  registered one-cycle pulse: all-zero state was detected and replaced by LFSR_SEED

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All state updates occur on the rising edge of clk. rst has priority over everything.
- Reset values: lfsr_o = LFSR_SEED, cntrst_o = 0, lockup_o = 0.
- Step function: step(q) = {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : 32'h0).
- Candidate next state, in priority order:
  1. seed_we_i = 1: candidate = seed_wdata_i. Any shift_i in the same cycle is dropped, not deferred.
  2. else if shift_i = 1: candidate = step(lfsr_o).
  3. else: candidate = lfsr_o (hold).
- Lockup guard: if candidate == 0, the register loads LFSR_SEED and lockup_o = 1 in the following cycle.
  - This covers a zero seed write and any corrupted state.
  - lockup_o otherwise = 0.
  - Holding an already-zero state also triggers the guard, so the register can never remain at 0 for more than one cycle.
- cntrst_o next value = seed_we_i | cpuctrl_we_i, i.e. a pulse exactly one cycle after the write.
  - Back-to-back write cycles give back-to-back pulses.
  - There is no merging or stretching.
- Latency:
  - shift_i or seed write to a new lfsr_o value: 1 cycle.
  - Write to cntrst_o: 1 cycle.
  - The new lfsr_o and cntrst_o become visible in the same cycle, so the consumer resets its counter against the new random interval.
- shift_i is a single-cycle event per retired dummy/hint. When shift_i is held high for N cycles, the LFSR advances N steps.
- No internal enables: gating by rnddummy is the consumer's job. shift_i is honoured regardless of cpuctrl.
- Reset asserted mid-operation (any inputs active) yields reset values on the next edge. Writes and shifts in the reset cycle are discarded.
- Implementation includes assertions:
  - lfsr_o never 0 outside the single recovery cycle.
  - cntrst_o never high without a write in the preceding cycle.
  - lockup_o implies lfsr_o == LFSR_SEED.

Test Plan:
- Reset, then shift_i pulses (defaults): lfsr_o = 32'h0000_0001 → 32'h8000_0057 → 32'hC000_007C → 32'h6000_003E; cntrst_o and lockup_o stay 0.
- seed_we_i=1 with seed_wdata_i=32'hDEAD_BEEF: next cycle lfsr_o = 32'hDEAD_BEEF and cntrst_o = 1 for one cycle. With seed_we_i=1 and shift_i=1 together, the result is identical (shift dropped).
- seed_we_i=1 with seed_wdata_i=0: next cycle lfsr_o = 32'h0000_0001, lockup_o = 1, cntrst_o = 1; both pulses clear the following cycle.
- cpuctrl_we_i high for 2 consecutive cycles with no shift: cntrst_o high for exactly the 2 following cycles; lfsr_o unchanged.
- shift_i held high 3 cycles from 32'h0000_0001, with rst asserted on cycle 3: lfsr_o reaches 32'hC000_007C, then returns to 32'h0000_0001 after the reset edge with all pulses 0.
- Force the internal state to 0 through the bench backdoor with shift_i=0: next cycle lfsr_o = 32'h0000_0001 and lockup_o = 1; the zero-state assertion fires only for the forced cycle.
